// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the CPU-side SRAM interface stage.
// Imported by the controller and by its counter sub-module.
package mc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mc_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping back to zero.
module mc_sat_cnt
  import mc_mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mc_mem_ctrl.sv
// Memory stage between the multicycle CPU bus and a synchronous single-port
// SRAM: one word per request, programmable wait states, range/alignment check.
module mc_mem_ctrl
  import mc_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_LOG2  = 10,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           adr,
  input  logic [31:0]           tom,
  output logic [31:0]           fromm,
  output logic                  ready,
  output logic                  err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  we_lat;
  logic                  err_flag;
  logic                  bad_adr;
  logic                  done_good;

  // Misaligned, or any bit set above the top word-address bit.
  assign bad_adr = (adr[1:0] != 2'b00) || ((adr >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      we_lat    <= 1'b0;
      err_flag  <= 1'b0;
      fromm     <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ready  <= 1'b0;
      err    <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_lat <= we;
            if (bad_adr) begin
              err_flag <= 1'b1;
              state    <= DONE;
            end else begin
              // SRAM strobes are registered here so they are high exactly in ACCESS.
              err_flag  <= 1'b0;
              mem_cs    <= 1'b1;
              mem_we    <= we;
              mem_addr  <= adr[DEPTH_LOG2+1:2];
              mem_wdata <= tom;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          wait_cnt <= WAIT_CNT_W'(1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            if (!we_lat) begin
              fromm <= mem_rdata;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          err   <= err_flag;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done_good = (state == DONE) && !err_flag;

  mc_sat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (done_good && !we_lat),
    .count (rd_count)
  );

  mc_sat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (done_good && we_lat),
    .count (wr_count)
  );

endmodule

// File: tb/tb_mc_mem_ctrl.sv
// Directed bench for mc_mem_ctrl: two instances (1 and 5 wait states), each
// with an SRAM model whose read data only turns valid late in the wait window.
module tb_mc_mem_ctrl;

  localparam int WA = 1;
  localparam int WB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, req, sel, we;
  logic [31:0] adr, tom;

  logic        req_a, req_b;
  logic [31:0] fromm_a, fromm_b, mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
  logic        ready_a, ready_b, err_a, err_b, mem_cs_a, mem_cs_b, mem_we_a, mem_we_b;
  logic [9:0]  mem_addr_a, mem_addr_b;
  logic [3:0]  rd_count_a, wr_count_a;
  logic [15:0] rd_count_b, wr_count_b;

  int total = 0;
  int bad = 0;

  assign req_a = req && !sel;
  assign req_b = req && sel;

  mc_mem_ctrl #(.WAIT_CYCLES(WA), .DEPTH_LOG2(10), .CNT_W(4)) dut_a (
    .clk(clk), .clr(clr), .req(req_a), .we(we), .adr(adr), .tom(tom),
    .fromm(fromm_a), .ready(ready_a), .err(err_a), .mem_cs(mem_cs_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .rd_count(rd_count_a), .wr_count(wr_count_a)
  );

  mc_mem_ctrl #(.WAIT_CYCLES(WB), .DEPTH_LOG2(10), .CNT_W(16)) dut_b (
    .clk(clk), .clr(clr), .req(req_b), .we(we), .adr(adr), .tom(tom),
    .fromm(fromm_b), .ready(ready_b), .err(err_b), .mem_cs(mem_cs_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .rd_count(rd_count_b), .wr_count(wr_count_b)
  );

  // Selected-instance views used by the shared access helper.
  logic        ready_o, err_o, mem_cs_o, mem_we_o;
  logic [31:0] fromm_o, mem_wdata_o;
  logic [9:0]  mem_addr_o;
  logic [15:0] rd_count_o, wr_count_o;
  assign ready_o     = sel ? ready_b : ready_a;
  assign err_o       = sel ? err_b : err_a;
  assign mem_cs_o    = sel ? mem_cs_b : mem_cs_a;
  assign mem_we_o    = sel ? mem_we_b : mem_we_a;
  assign fromm_o     = sel ? fromm_b : fromm_a;
  assign mem_wdata_o = sel ? mem_wdata_b : mem_wdata_a;
  assign mem_addr_o  = sel ? mem_addr_b : mem_addr_a;
  assign rd_count_o  = sel ? rd_count_b : {12'd0, rd_count_a};
  assign wr_count_o  = sel ? wr_count_b : {12'd0, wr_count_a};

  // SRAM models: data is garbage until WAIT_CYCLES-1 edges after the chip-select edge.
  logic [31:0] sram_a [0:1023];
  logic [31:0] sram_b [0:1023];
  logic [31:0] hold_a, hold_b;
  int age_a = 100;
  int age_b = 100;

  always @(posedge clk) begin
    if (mem_cs_a) begin
      if (mem_we_a) sram_a[mem_addr_a] <= mem_wdata_a;
      hold_a <= sram_a[mem_addr_a];
      age_a  <= 0;
    end else if (age_a < 100) begin
      age_a <= age_a + 1;
    end
    if (mem_cs_b) begin
      if (mem_we_b) sram_b[mem_addr_b] <= mem_wdata_b;
      hold_b <= sram_b[mem_addr_b];
      age_b  <= 0;
    end else if (age_b < 100) begin
      age_b <= age_b + 1;
    end
  end

  assign mem_rdata_a = (age_a >= WA - 1) ? hold_a : 32'hBAD0_BAD0;
  assign mem_rdata_b = (age_b >= WB - 1) ? hold_b : 32'hBAD0_BAD0;

  // Runs one access on the selected instance; n counts negedges after the drive,
  // so the accepting edge is followed by n=1. Inputs are scrambled after acceptance.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int rdy_n, output logic err_s, output int cs_n,
                           output int cs_at, output int we_n, output logic [9:0] addr_s,
                           output logic [31:0] wdata_s);
    rdy_n = -1; err_s = 1'b0; cs_n = 0; cs_at = -1; we_n = 0; addr_s = '0; wdata_s = '0;
    @(negedge clk);
    we = w; adr = a; tom = d; req = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        we = ~w; adr = ~a; tom = ~d;
      end
      if (mem_cs_o) begin
        cs_n++; cs_at = n; addr_s = mem_addr_o; wdata_s = mem_wdata_o;
      end
      if (mem_we_o) we_n++;
      if (ready_o) begin
        rdy_n = n; err_s = err_o; req = 1'b0;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({fromm_a, ready_a, err_a, mem_cs_a, mem_we_a, mem_addr_a, mem_wdata_a, rd_count_a, wr_count_a} !== '0) begin
      bad++;
      $display("FAIL reset_a got fromm=%h rdy=%b err=%b cs=%b we=%b addr=%h wd=%h rc=%h wc=%h exp all zero",
               fromm_a, ready_a, err_a, mem_cs_a, mem_we_a, mem_addr_a, mem_wdata_a, rd_count_a, wr_count_a);
    end
    total++;
    if ({fromm_b, ready_b, err_b, mem_cs_b, mem_we_b, mem_addr_b, mem_wdata_b, rd_count_b, wr_count_b} !== '0) begin
      bad++;
      $display("FAIL reset_b got fromm=%h rdy=%b err=%b cs=%b we=%b addr=%h wd=%h rc=%h wc=%h exp all zero",
               fromm_b, ready_b, err_b, mem_cs_b, mem_we_b, mem_addr_b, mem_wdata_b, rd_count_b, wr_count_b);
    end
    clr = 1'b0;
    $display("reset: both instances cleared");
  endtask

  task automatic test_wait_scaling();
    int rn, cn, ca, wn; logic e; logic [9:0] ad; logic [31:0] wd;
    sel = 1'b1;
    do_access(1'b1, 32'h20, 32'h1234_5678, rn, e, cn, ca, wn, ad, wd);
    total++; if (rn !== 8) begin bad++; $display("FAIL ws_write_latency got=%0d exp=8", rn); end
    total++; if ({cn, ca, wn} !== {32'd1, 32'd1, 32'd1}) begin bad++; $display("FAIL ws_write_strobes got cs_n=%0d cs_at=%0d we_n=%0d exp 1 1 1", cn, ca, wn); end
    total++; if ({ad, wd} !== {10'h008, 32'h1234_5678}) begin bad++; $display("FAIL ws_write_bus got addr=%h wd=%h exp 008 12345678", ad, wd); end
    $display("wait5 write adr=20 ready_at=%0d", rn);
    do_access(1'b0, 32'h20, 32'h0, rn, e, cn, ca, wn, ad, wd);
    total++; if (rn !== 8) begin bad++; $display("FAIL ws_read_latency got=%0d exp=8", rn); end
    total++; if ({cn, ca, wn} !== {32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL ws_read_strobes got cs_n=%0d cs_at=%0d we_n=%0d exp 1 1 0", cn, ca, wn); end
    total++; if (fromm_b !== 32'h1234_5678) begin bad++; $display("FAIL ws_read_data got=%h exp=12345678", fromm_b); end
    total++; if ({rd_count_b, wr_count_b} !== {16'd1, 16'd1}) begin bad++; $display("FAIL ws_counts got rd=%0d wr=%0d exp 1 1", rd_count_b, wr_count_b); end
    $display("wait5 read adr=20 ready_at=%0d fromm=%h", rn, fromm_b);
  endtask

  task automatic test_reset_mid_access();
    int seen;
    sel = 1'b1;
    @(negedge clk);
    we = 1'b0; adr = 32'h10; tom = 32'h0; req = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1; req = 1'b0;
    @(negedge clk);
    total++;
    if ({fromm_b, ready_b, err_b, mem_cs_b, mem_we_b, mem_addr_b, mem_wdata_b, rd_count_b, wr_count_b} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got fromm=%h rdy=%b err=%b cs=%b we=%b addr=%h wd=%h rc=%h wc=%h exp all zero",
               fromm_b, ready_b, err_b, mem_cs_b, mem_we_b, mem_addr_b, mem_wdata_b, rd_count_b, wr_count_b);
    end
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready_b || mem_cs_b) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_quiet got=%0d exp=0", seen); end
    $display("reset during WAIT: aborted, strays=%0d", seen);
  endtask

  task automatic test_write_read();
    int rn, cn, ca, wn; logic e; logic [9:0] ad; logic [31:0] wd;
    sel = 1'b0;
    do_access(1'b1, 32'h40, 32'hDEAD_BEEF, rn, e, cn, ca, wn, ad, wd);
    total++; if ({rn, e} !== {32'd4, 1'b0}) begin bad++; $display("FAIL wr_latency got=%0d err=%b exp 4 0", rn, e); end
    total++; if ({cn, ca, wn} !== {32'd1, 32'd1, 32'd1}) begin bad++; $display("FAIL wr_strobes got cs_n=%0d cs_at=%0d we_n=%0d exp 1 1 1", cn, ca, wn); end
    total++; if ({ad, wd} !== {10'h010, 32'hDEAD_BEEF}) begin bad++; $display("FAIL wr_bus got addr=%h wd=%h exp 010 deadbeef", ad, wd); end
    total++; if (wr_count_a !== 4'd1) begin bad++; $display("FAIL wr_count got=%0d exp=1", wr_count_a); end
    $display("write adr=40 data=deadbeef ready_at=%0d", rn);
    do_access(1'b0, 32'h40, 32'h0, rn, e, cn, ca, wn, ad, wd);
    total++; if ({rn, wn} !== {32'd4, 32'd0}) begin bad++; $display("FAIL rd_latency got=%0d we_n=%0d exp 4 0", rn, wn); end
    total++; if (fromm_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", fromm_a); end
    total++; if (rd_count_a !== 4'd1) begin bad++; $display("FAIL rd_count got=%0d exp=1", rd_count_a); end
    $display("read adr=40 fromm=%h ready_at=%0d", fromm_a, rn);
  endtask

  task automatic test_misaligned();
    int rn, cn, ca, wn; logic e; logic [9:0] ad; logic [31:0] wd;
    sel = 1'b0;
    do_access(1'b0, 32'h42, 32'h0, rn, e, cn, ca, wn, ad, wd);
    total++; if ({rn, e} !== {32'd2, 1'b1}) begin bad++; $display("FAIL mis_ready got=%0d err=%b exp 2 1", rn, e); end
    total++; if (cn !== 0) begin bad++; $display("FAIL mis_no_cs got=%0d exp=0", cn); end
    total++; if (fromm_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mis_fromm got=%h exp=deadbeef", fromm_a); end
    total++; if ({rd_count_a, wr_count_a} !== {4'd1, 4'd1}) begin bad++; $display("FAIL mis_counts got rd=%0d wr=%0d exp 1 1", rd_count_a, wr_count_a); end
    $display("read adr=42 err=%b ready_at=%0d", e, rn);
  endtask

  task automatic test_out_of_range();
    int rn, cn, ca, wn; logic e; logic [9:0] ad; logic [31:0] wd;
    sel = 1'b0;
    do_access(1'b1, 32'h1000, 32'h5555_AAAA, rn, e, cn, ca, wn, ad, wd);
    total++; if ({rn, e} !== {32'd2, 1'b1}) begin bad++; $display("FAIL oor_ready got=%0d err=%b exp 2 1", rn, e); end
    total++; if ({cn, wn} !== {32'd0, 32'd0}) begin bad++; $display("FAIL oor_no_access got cs_n=%0d we_n=%0d exp 0 0", cn, wn); end
    total++; if (wr_count_a !== 4'd1) begin bad++; $display("FAIL oor_wr_count got=%0d exp=1", wr_count_a); end
    $display("write adr=1000 err=%b ready_at=%0d", e, rn);
    do_access(1'b1, 32'hFFC, 32'h0BAD_F00D, rn, e, cn, ca, wn, ad, wd);
    total++; if ({rn, e, ad} !== {32'd4, 1'b0, 10'h3FF}) begin bad++; $display("FAIL top_word got rdy=%0d err=%b addr=%h exp 4 0 3ff", rn, e, ad); end
    total++; if (wr_count_a !== 4'd2) begin bad++; $display("FAIL top_word_count got=%0d exp=2", wr_count_a); end
    $display("write adr=ffc err=%b addr=%h ready_at=%0d", e, ad, rn);
  endtask

  task automatic test_back_to_back();
    int cnt, prev, extra;
    sel = 1'b0; cnt = 0; prev = 0; extra = 0;
    @(negedge clk);
    we = 1'b0; adr = 32'h40; tom = 32'h0; req = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (ready_a) begin
        cnt++;
        total++;
        if ({n - prev, err_a, fromm_a} !== {32'd4, 1'b0, 32'hDEAD_BEEF}) begin
          bad++;
          $display("FAIL b2b_access%0d got gap=%0d err=%b fromm=%h exp 4 0 deadbeef", cnt, n - prev, err_a, fromm_a);
        end
        if (cnt == 13) begin
          total++; if (rd_count_a !== 4'd14) begin bad++; $display("FAIL b2b_count13 got=%0d exp=14", rd_count_a); end
        end
        if (cnt == 14) begin
          total++; if (rd_count_a !== 4'd15) begin bad++; $display("FAIL b2b_count14 got=%0d exp=15", rd_count_a); end
        end
        $display("b2b read %0d ready_at=%0d rd_count=%0d", cnt, n, rd_count_a);
        prev = n;
        if (cnt == 20) begin
          req = 1'b0;
          break;
        end
      end
    end
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready_a || mem_cs_a) extra++;
    end
    total++; if ({cnt, extra} !== {32'd20, 32'd0}) begin bad++; $display("FAIL b2b_total got=%0d extra=%0d exp 20 0", cnt, extra); end
    total++; if (rd_count_a !== 4'd15) begin bad++; $display("FAIL b2b_saturate got=%0d exp=15", rd_count_a); end
  endtask

  initial begin
    clr = 1'b1; req = 1'b0; sel = 1'b0; we = 1'b0; adr = '0; tom = '0;
    for (int i = 0; i < 1024; i++) begin
      sram_a[i] = 32'hA500_0000 | i;
      sram_b[i] = 32'h5A00_0000 | i;
    end
    test_reset();
    test_wait_scaling();
    test_reset_mid_access();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
